game_timer: RTL and testbench

- Parametrised successor to the fixed one-minute-field countdown used by the game top level.
- Supports count-down (time limit) and count-up (stopwatch) modes, pause/resume, run-time bonus/penalty seconds, saturation, and expiry signalling.
- Provides BCD seconds digits for the HEX display path.
- Sits beside the game-state FSM: the FSM drives load/enable; expired feeds the lose condition.

---
 rtl/game_timer_if.sv | 35 +++
 rtl/game_timer.sv | 187 ++++++++++++++++++
 tb/tb_game_timer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_timer_if.sv
// Control and status bundle for game_timer: load/adjust/enable commands in,
// time, BCD digits and expiry status out.
interface game_timer_if #(
    parameter int unsigned MIN_W = 4
);
    logic             load;
    logic [MIN_W-1:0] minute_in;
    logic [5:0]       second_in;
    logic             count_up;
    logic             enable;
    logic             adj_valid;
    logic             adj_sub;
    logic [5:0]       adj_sec;

    logic [MIN_W-1:0] minute_out;
    logic [5:0]       second_out;
    logic [3:0]       sec_tens;
    logic [3:0]       sec_ones;
    logic             tick;
    logic             running;
    logic             expired;
    logic             expire_pulse;

    modport master (
        output load, minute_in, second_in, count_up, enable, adj_valid, adj_sub, adj_sec,
        input  minute_out, second_out, sec_tens, sec_ones, tick, running, expired,
               expire_pulse
    );

    modport slave (
        input  load, minute_in, second_in, count_up, enable, adj_valid, adj_sub, adj_sec,
        output minute_out, second_out, sec_tens, sec_ones, tick, running, expired,
               expire_pulse
    );
endinterface

// File: rtl/game_timer.sv
// Parametrised minutes:seconds game timer with count-down/up modes, pause,
// saturating bonus/penalty adjustment, expiry signalling and BCD seconds digits.
module game_timer #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MIN_W    = 4
) (
    input logic         clk,
    input logic         reset,
    game_timer_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [MIN_W-1:0]        MIN_MAX   = '1;
    localparam logic signed [MIN_W+1:0] MIN_MAX_S = $signed({2'b00, MIN_MAX});
    localparam logic signed [MIN_W+1:0] ONE_S     = {{(MIN_W+1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [MIN_W-1:0] minute_q, minute_d;
    logic [5:0]       second_q, second_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             pulse_q, pulse_d;

    logic                    active;
    logic                    count_en;
    logic                    step;
    logic                    adj_en;
    logic signed [7:0]       adj_s;
    logic signed [7:0]       delta;
    logic signed [7:0]       sec_s;
    logic signed [MIN_W+1:0] min_s;
    logic [MIN_W-1:0]        nxt_min;
    logic [5:0]              nxt_sec;
    logic                    at_end;
    logic [5:0]              load_sec;

    function automatic logic [7:0] to_bcd(input logic [5:0] s);
        logic [3:0] t;
        logic [5:0] r;
        if (s >= 6'd50) begin
            t = 4'd5;
            r = s - 6'd50;
        end else if (s >= 6'd40) begin
            t = 4'd4;
            r = s - 6'd40;
        end else if (s >= 6'd30) begin
            t = 4'd3;
            r = s - 6'd30;
        end else if (s >= 6'd20) begin
            t = 4'd2;
            r = s - 6'd20;
        end else if (s >= 6'd10) begin
            t = 4'd1;
            r = s - 6'd10;
        end else begin
            t = 4'd0;
            r = s;
        end
        return {t, r[3:0]};
    endfunction

    assign active   = (state_q == RUN) || (state_q == PAUSE);
    assign count_en = (state_q == RUN) && bus.enable;
    assign step     = count_en && (presc_q == PRESC_LAST);
    assign adj_en   = active && bus.adj_valid;
    assign adj_s    = $signed({2'b00, bus.adj_sec});
    assign load_sec = (bus.second_in > 6'd59) ? 6'd59 : bus.second_in;

    // Step and adjustment are folded into one signed delta (|delta| <= 64),
    // so at most two +/-60 corrections bring seconds back into 0..59.
    always_comb begin
        delta = 8'sd0;
        if (step) begin
            delta = mode_q ? 8'sd1 : -8'sd1;
        end
        if (adj_en) begin
            delta = bus.adj_sub ? (delta - adj_s) : (delta + adj_s);
        end

        sec_s = $signed({2'b00, second_q}) + delta;
        min_s = $signed({2'b00, minute_q});
        for (int i = 0; i < 2; i++) begin
            if (sec_s[7]) begin
                sec_s = sec_s + 8'sd60;
                min_s = min_s - ONE_S;
            end else if (sec_s > 8'sd59) begin
                sec_s = sec_s - 8'sd60;
                min_s = min_s + ONE_S;
            end
        end

        if (min_s[MIN_W+1]) begin
            nxt_min = '0;
            nxt_sec = 6'd0;
        end else if (min_s > MIN_MAX_S) begin
            nxt_min = MIN_MAX;
            nxt_sec = 6'd59;
        end else begin
            nxt_min = min_s[MIN_W-1:0];
            nxt_sec = sec_s[5:0];
        end

        at_end = mode_q ? ((nxt_min == MIN_MAX) && (nxt_sec == 6'd59))
                        : ((nxt_min == '0) && (nxt_sec == 6'd0));
    end

    always_comb begin
        state_d  = state_q;
        minute_d = minute_q;
        second_d = second_q;
        presc_d  = presc_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        pulse_d  = 1'b0;

        if (bus.load) begin
            state_d  = bus.enable ? RUN : PAUSE;
            minute_d = bus.minute_in;
            second_d = load_sec;
            mode_d   = bus.count_up;
            presc_d  = '0;
        end else if (active) begin
            minute_d = nxt_min;
            second_d = nxt_sec;
            tick_d   = step;
            if (count_en) begin
                presc_d = step ? '0 : presc_q + 1'b1;
            end
            // A terminal value reached by any route (tick, adjust or a
            // terminal load one cycle earlier) ends the count here.
            if (at_end) begin
                state_d = DONE;
                pulse_d = 1'b1;
            end else if ((state_q == RUN) && !bus.enable) begin
                state_d = PAUSE;
            end else if ((state_q == PAUSE) && bus.enable) begin
                state_d = RUN;
            end
        end

        {tens_d, ones_d} = to_bcd(second_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            minute_q <= '0;
            second_q <= 6'd0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            presc_q  <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            minute_q <= minute_d;
            second_q <= second_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            presc_q  <= presc_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            pulse_q  <= pulse_d;
        end
    end

    assign bus.minute_out   = minute_q;
    assign bus.second_out   = second_q;
    assign bus.sec_tens     = tens_q;
    assign bus.sec_ones     = ones_q;
    assign bus.tick         = tick_q;
    assign bus.running      = (state_q == RUN);
    assign bus.expired      = (state_q == DONE);
    assign bus.expire_pulse = pulse_q;

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: stimulus queues expected tick/expiry events
// and state snapshots; a negedge monitor pops and compares them.
module tb_game_timer;

    logic clk;
    logic reset;
    int   cyc;
    int   n_total;
    int   n_pass;
    logic snap_req;

    typedef struct {
        string tag;
        int    cyc;
        int    mn;
        int    sc;
        int    tk;
        int    ex;
        int    ep;
        int    rn;
    } exp_t;

    exp_t ev_q[$];
    exp_t snap_q[$];

    game_timer_if #(.MIN_W(4)) tif ();

    game_timer #(
        .TICK_DIV(4),
        .MIN_W   (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Events are compared whenever the DUT presents tick or expire_pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tif.tick || tif.expire_pulse) begin
                if (ev_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: cyc %0d tick %0d pulse %0d time %0d:%0d",
                             cyc, tif.tick, tif.expire_pulse, tif.minute_out, tif.second_out);
                end else begin
                    e = ev_q.pop_front();
                    chk({e.tag, ".cyc"}, cyc, e.cyc);
                    chk({e.tag, ".min"}, int'(tif.minute_out), e.mn);
                    chk({e.tag, ".sec"}, int'(tif.second_out), e.sc);
                    chk({e.tag, ".tens"}, int'(tif.sec_tens), e.sc / 10);
                    chk({e.tag, ".ones"}, int'(tif.sec_ones), e.sc % 10);
                    chk({e.tag, ".tick"}, int'(tif.tick), e.tk);
                    chk({e.tag, ".expired"}, int'(tif.expired), e.ex);
                    chk({e.tag, ".pulse"}, int'(tif.expire_pulse), e.ep);
                end
            end
            if (snap_req) begin
                e = snap_q.pop_front();
                chk({e.tag, ".min"}, int'(tif.minute_out), e.mn);
                chk({e.tag, ".sec"}, int'(tif.second_out), e.sc);
                chk({e.tag, ".tens"}, int'(tif.sec_tens), e.sc / 10);
                chk({e.tag, ".ones"}, int'(tif.sec_ones), e.sc % 10);
                chk({e.tag, ".tick"}, int'(tif.tick), e.tk);
                chk({e.tag, ".expired"}, int'(tif.expired), e.ex);
                chk({e.tag, ".pulse"}, int'(tif.expire_pulse), e.ep);
                chk({e.tag, ".running"}, int'(tif.running), e.rn);
            end
        end
    end

    task automatic push_ev(input string tag, input int c, input int mn, input int sc,
                           input int tk, input int ex, input int ep);
        exp_t e;
        e = '{tag: tag, cyc: c, mn: mn, sc: sc, tk: tk, ex: ex, ep: ep, rn: 0};
        ev_q.push_back(e);
    endtask

    task automatic snap(input string tag, input int mn, input int sc, input int tk,
                        input int ex, input int ep, input int rn);
        exp_t e;
        e = '{tag: tag, cyc: 0, mn: mn, sc: sc, tk: tk, ex: ex, ep: ep, rn: rn};
        snap_q.push_back(e);
        snap_req = 1'b1;
        @(negedge clk);
        #1 snap_req = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
    endtask

    // Returns the index of the clock edge that samples load.
    task automatic do_load(input int mn, input int sc, input logic up, input logic en,
                           output int t0);
        @(posedge clk);
        #1;
        tif.load      = 1'b1;
        tif.minute_in = 4'(mn);
        tif.second_in = 6'(sc);
        tif.count_up  = up;
        tif.enable    = en;
        wait_cycles(1);
        tif.load = 1'b0;
        t0 = cyc;
    endtask

    task automatic pulse_adj(input logic sub, input int sec);
        tif.adj_valid = 1'b1;
        tif.adj_sub   = sub;
        tif.adj_sec   = 6'(sec);
        wait_cycles(1);
        tif.adj_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int t0;
        cyc           = 0;
        n_total       = 0;
        n_pass        = 0;
        snap_req      = 1'b0;
        reset         = 1'b1;
        tif.load      = 1'b0;
        tif.minute_in = '0;
        tif.second_in = '0;
        tif.count_up  = 1'b0;
        tif.enable    = 1'b0;
        tif.adj_valid = 1'b0;
        tif.adj_sub   = 1'b0;
        tif.adj_sec   = '0;
        wait_cycles(2);
        reset = 1'b0;
        snap("reset", 0, 0, 0, 0, 0, 0);

        // 0:03 down: ticks every 4 cycles, expiry on the third.
        do_load(0, 3, 1'b0, 1'b1, t0);
        push_ev("dn1", t0 + 4, 0, 2, 1, 0, 0);
        push_ev("dn2", t0 + 8, 0, 1, 1, 0, 0);
        push_ev("dn3", t0 + 12, 0, 0, 1, 1, 1);
        snap("dn_run", 0, 3, 0, 0, 0, 1);
        wait_cycles(14);
        snap("dn_hold", 0, 0, 0, 1, 0, 0);
        chk("dn_drained", ev_q.size(), 0);

        // Minute borrow: 1:00 -> 0:59.
        do_reset();
        do_load(1, 0, 1'b0, 1'b1, t0);
        push_ev("borrow", t0 + 4, 0, 59, 1, 0, 0);
        wait_cycles(5);
        tif.enable = 1'b0;
        snap("borrow_snap", 0, 59, 0, 0, 0, 1);

        // Pause holds the prescaler at 2; resume ticks two cycles later.
        do_reset();
        do_load(0, 10, 1'b0, 1'b1, t0);
        wait_cycles(2);
        tif.enable = 1'b0;
        wait_cycles(20);
        snap("paused", 0, 10, 0, 0, 0, 0);
        push_ev("resume", t0 + 25, 0, 9, 1, 0, 0);
        tif.enable = 1'b1;
        wait_cycles(3);
        snap("resumed", 0, 9, 1, 0, 0, 1);

        // Penalty saturates to 0:00 and expires; later bonus is ignored in DONE.
        do_reset();
        do_load(0, 5, 1'b0, 1'b1, t0);
        push_ev("pen_sat", t0 + 1, 0, 0, 0, 1, 1);
        pulse_adj(1'b1, 9);
        pulse_adj(1'b0, 30);
        wait_cycles(3);
        snap("done_adj", 0, 0, 0, 1, 0, 0);

        // Up mode: tick plus bonus 5 from 15:58 saturates at 15:59.
        do_reset();
        do_load(15, 58, 1'b1, 1'b1, t0);
        push_ev("up_sat", t0 + 4, 15, 59, 1, 1, 1);
        wait_cycles(3);
        pulse_adj(1'b0, 5);
        wait_cycles(1);
        snap("up_done", 15, 59, 0, 1, 0, 0);
        do_load(0, 0, 1'b1, 1'b0, t0);
        snap("reload", 0, 0, 0, 0, 0, 0);
        wait_cycles(3);
        snap("reload_hold", 0, 0, 0, 0, 0, 0);

        // Terminal load: one cycle in RUN, then DONE.
        do_load(0, 0, 1'b0, 1'b1, t0);
        push_ev("term_load", t0 + 1, 0, 0, 0, 1, 1);
        snap("term_run", 0, 0, 0, 0, 0, 1);
        wait_cycles(2);

        // Seconds clamp, then load wins over a same-cycle adjust.
        do_load(2, 63, 1'b0, 1'b0, t0);
        snap("clamp", 2, 59, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        tif.load      = 1'b1;
        tif.minute_in = 4'd0;
        tif.second_in = 6'd20;
        tif.count_up  = 1'b0;
        tif.enable    = 1'b0;
        tif.adj_valid = 1'b1;
        tif.adj_sub   = 1'b0;
        tif.adj_sec   = 6'd10;
        wait_cycles(1);
        tif.load      = 1'b0;
        tif.adj_valid = 1'b0;
        snap("load_wins", 0, 20, 0, 0, 0, 0);
        wait_cycles(2);
        snap("load_wins_hold", 0, 20, 0, 0, 0, 0);

        // Reset mid-count clears everything; IDLE never ticks.
        do_load(3, 30, 1'b0, 1'b1, t0);
        push_ev("pre_rst", t0 + 4, 3, 29, 1, 0, 0);
        wait_cycles(6);
        reset = 1'b1;
        snap("rst_mid", 0, 0, 0, 0, 0, 0);
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(8);
        snap("idle_after_rst", 0, 0, 0, 0, 0, 0);

        chk("ev_q_empty", ev_q.size(), 0);
        chk("snap_q_empty", snap_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
